// File: rtl/cla_addsub_pipe.sv
// -----------------------------------------------------------------------------
// cla_addsub_pipe
//
// Pipelined carry-lookahead adder/subtractor for the DSP datapath.
// A WIDTH-bit add or subtract is split into STAGES = WIDTH/GROUP groups. Each
// pipeline stage resolves one GROUP-bit group with a full lookahead carry
// network and registers the group carry-out for the next stage. Operand bits
// that are not yet consumed travel forward with the operation, shrinking by one
// group per stage. Resolved low sum bits travel forward too, growing by one
// group per stage. The last stage detects signed overflow and can saturate.
//
// Parameters
//   WIDTH  : operand/result width, a multiple of GROUP
//   GROUP  : bits resolved per stage
//   SAT_EN : 1 = saturate to the signed limit on overflow, 0 = wrap
//
// Ports
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   operands valid
//   in_ready   operation can be accepted this cycle
//   a, b       operands
//   cin        carry-in for add mode (ignored when sub=1)
//   sub        0: a+b+cin, 1: a-b computed as a+~b+1
//   out_valid  result valid
//   out_ready  downstream accepts the result
//   sum        result, wrapped or saturated
//   cout       raw carry out of the MSB (sub mode: 1 = no borrow)
//   ovf        signed overflow, reported even when the sum is saturated
//
// Latency is STAGES register levels. An operation accepted at edge N is on
// the outputs after edge N+STAGES-1. Throughput is one result per cycle.
// The whole pipe stalls as a unit while the output holds an unaccepted result.
// -----------------------------------------------------------------------------
module cla_addsub_pipe #(
  parameter int WIDTH  = 32,
  parameter int GROUP  = 8,
  parameter bit SAT_EN = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int STAGES = WIDTH / GROUP;

  if ((GROUP < 1) || (WIDTH < GROUP) || ((WIDTH % GROUP) != 0)) begin : g_bad_params
    $error("cla_addsub_pipe: WIDTH must be a non-zero multiple of GROUP");
  end

  // Lookahead carry network for one group. Every carry c[i] is the flat
  // sum-of-products of the generate/propagate terms below it and the group
  // carry-in, so no carry depends on another carry inside the group.
  function automatic logic [GROUP:0] cla_carries(
    input logic [GROUP-1:0] g,
    input logic [GROUP-1:0] p,
    input logic             c0
  );
    logic [GROUP:0] c;
    logic           term;
    c    = '0;
    c[0] = c0;
    for (int i = 1; i <= GROUP; i++) begin
      // carry-in propagated through every bit below i
      term = c0;
      for (int j = 0; j < i; j++) term = term & p[j];
      c[i] = term;
      // generate at bit j propagated through bits j+1 .. i-1
      for (int j = 0; j < i; j++) begin
        term = g[j];
        for (int m = j + 1; m < i; m++) term = term & p[m];
        c[i] = c[i] | term;
      end
    end
    return c;
  endfunction

  // ---------------------------------------------------------------------------
  // Flow control
  // ---------------------------------------------------------------------------
  logic             w_adv;      // whole pipe moves one step this cycle
  logic             w_accept;   // an input transfer happens this cycle
  logic [WIDTH-1:0] w_bp;       // b or ~b depending on mode
  logic             w_c0;       // carry into group 0

  logic             r_out_valid;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;

  // Last-stage results, ready to be registered into the output.
  logic             w_fin_v;
  logic [WIDTH-1:0] w_fin_sum;
  logic             w_fin_cout;
  logic             w_fin_ovf;

  assign w_adv    = ~r_out_valid | out_ready;
  assign in_ready = w_adv & ~rst;
  assign w_accept = in_valid & in_ready;

  // Subtraction is a + ~b + 1, so the "+1" rides in as the group-0 carry.
  assign w_bp = sub ? ~b : b;
  assign w_c0 = sub | cin;

  // ---------------------------------------------------------------------------
  // Stages. Stage k sees the operand bits from group k upwards (w_a_rem,
  // w_bp_rem), the carry into group k and the resolved sum bits of groups
  // 0..k-1. It resolves group k and hands the rest to stage k+1.
  // ---------------------------------------------------------------------------
  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    localparam int RW = WIDTH - k * GROUP;   // operand bits still unresolved
    localparam int SW = (k + 1) * GROUP;     // sum bits resolved after stage

    logic [RW-1:0]    w_a_rem;
    logic [RW-1:0]    w_bp_rem;
    logic             w_c_in;
    logic             w_v_in;
    logic [GROUP-1:0] w_g;
    logic [GROUP-1:0] w_p;
    logic [GROUP:0]   w_c;
    logic [GROUP-1:0] w_sum_g;
    logic [SW-1:0]    w_s_full;

    assign w_g     = w_a_rem[GROUP-1:0] & w_bp_rem[GROUP-1:0];
    assign w_p     = w_a_rem[GROUP-1:0] ^ w_bp_rem[GROUP-1:0];
    assign w_c     = cla_carries(w_g, w_p, w_c_in);
    assign w_sum_g = w_p ^ w_c[GROUP-1:0];

    if (k == 0) begin : g_src
      assign w_a_rem  = a;
      assign w_bp_rem = w_bp;
      assign w_c_in   = w_c0;
      assign w_v_in   = w_accept;
      assign w_s_full = w_sum_g;
    end else begin : g_src
      assign w_a_rem  = g_stg[k-1].g_mid.r_a_hi;
      assign w_bp_rem = g_stg[k-1].g_mid.r_bp_hi;
      assign w_c_in   = g_stg[k-1].g_mid.r_c;
      assign w_v_in   = g_stg[k-1].g_mid.r_v;
      assign w_s_full = {w_sum_g, g_stg[k-1].g_mid.r_s_lo};
    end

    if (k == STAGES - 1) begin : g_out
      logic w_ovf;

      // Carry into the MSB differs from carry out of the MSB exactly when
      // the signed result does not fit.
      assign w_ovf      = w_c[GROUP] ^ w_c[GROUP-1];
      assign w_fin_v    = w_v_in;
      assign w_fin_cout = w_c[GROUP];
      assign w_fin_ovf  = w_ovf;

      if (SAT_EN) begin : g_sat
        logic w_a_msb;
        // On overflow both operand signs agree, so the sign of a tells which
        // limit was crossed: negative operands clamp to 100..0, positive
        // operands clamp to 011..1.
        assign w_a_msb   = w_a_rem[GROUP-1];
        assign w_fin_sum = w_ovf ? {w_a_msb, {(WIDTH-1){~w_a_msb}}} : w_s_full;
      end else begin : g_wrap
        assign w_fin_sum = w_s_full;
      end
    end else begin : g_mid
      logic [RW-GROUP-1:0] r_a_hi;
      logic [RW-GROUP-1:0] r_bp_hi;
      logic [SW-1:0]       r_s_lo;
      logic                r_c;
      logic                r_v;

      // NOTE: state registers use non-blocking assignments so every stage
      // samples its predecessor's value from before the edge, not the one
      // being written at the same edge.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_v <= 1'b0;
        end else if (w_adv) begin
          r_v <= w_v_in;
        end
      end

      // NOTE: the datapath registers are left out of reset on purpose. A
      // cleared valid bit already marks their contents as meaningless, and
      // skipping the reset keeps it off the wide operand/sum fan-out.
      always_ff @(posedge clk) begin
        if (w_adv) begin
          r_a_hi  <= w_a_rem[RW-1:GROUP];
          r_bp_hi <= w_bp_rem[RW-1:GROUP];
          r_s_lo  <= w_s_full;
          r_c     <= w_c[GROUP];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output register. The data fields load only with a valid result, so a
  // bubble keeps the last result on the bus while out_valid reads 0.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_sum       <= '0;
      r_cout      <= 1'b0;
      r_ovf       <= 1'b0;
    end else if (w_adv) begin
      r_out_valid <= w_fin_v;
      if (w_fin_v) begin
        r_sum  <= w_fin_sum;
        r_cout <= w_fin_cout;
        r_ovf  <= w_fin_ovf;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign ovf       = r_ovf;

endmodule
